muldiv_unit: RTL and testbench

//  Iterative integer multiply/divide engine instantiated inside the execute stage.

---
 rtl/muldiv_if.sv | 39 +++
 rtl/muldiv_unit.sv | 223 ++++++++++++++++++++++
 tb/tb_muldiv_unit.sv | 382 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/muldiv_if.sv
// ---------------------------------------------------------------------------
// muldiv_if
// Request/response bundle between the execute stage and the iterative
// multiply/divide engine.
//   valid_i   start request (sampled when the engine can accept)
//   op_i      0=MUL 1=DIV 2=DIVU 3=REM 4=REMU, 5..7 reserved
//   word_i    1 selects the 32-bit W form of the operation
//   a_i       dividend / multiplicand
//   b_i       divisor / multiplier
//   flush_i   abort whatever is in flight
//   busy_o    engine is iterating; execute holds its stall
//   done_o    one-cycle pulse, result_o valid in this cycle
//   result_o  last produced result, held until the next accepted start
// The engine connects to the slave modport, the execute stage (or a
// testbench) to the master modport.
// ---------------------------------------------------------------------------
interface muldiv_if #(
    parameter int XLEN = 64
);
    logic            valid_i;
    logic [2:0]      op_i;
    logic            word_i;
    logic [XLEN-1:0] a_i;
    logic [XLEN-1:0] b_i;
    logic            flush_i;
    logic            busy_o;
    logic            done_o;
    logic [XLEN-1:0] result_o;

    modport master (
        output valid_i, op_i, word_i, a_i, b_i, flush_i,
        input  busy_o, done_o, result_o
    );

    modport slave (
        input  valid_i, op_i, word_i, a_i, b_i, flush_i,
        output busy_o, done_o, result_o
    );
endinterface

// File: rtl/muldiv_unit.sv
// ---------------------------------------------------------------------------
// muldiv_unit
// Iterative integer multiply/divide engine for the execute stage. One shared
// datapath runs shift-add multiplication or restoring division, one bit per
// cycle, with a single operation in flight.
// Ports:
//   clk    clock, all state changes on the rising edge
//   reset  asynchronous, active-high; clears all state immediately
//   bus    muldiv_if slave modport (request, flush, busy/done/result)
// Parameters:
//   XLEN   operand/result width; W forms work on the low 32 bits
//   CNT_W  iteration counter width, must hold the value XLEN
// ---------------------------------------------------------------------------
module muldiv_unit #(
    parameter int XLEN  = 64,
    parameter int CNT_W = 7
) (
    input  logic    clk,
    input  logic    reset,
    muldiv_if.slave bus
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [2:0] OP_MUL  = 3'd0;
    localparam logic [2:0] OP_DIV  = 3'd1;
    localparam logic [2:0] OP_REM  = 3'd3;
    localparam logic [2:0] OP_REMU = 3'd4;

    function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
        return {{(XLEN-32){v[31]}}, v};
    endfunction

    logic [1:0]      state;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] iter_limit;

    // acc: product accumulator / partial remainder
    // opa: multiplier (shifts right) / dividend that fills with quotient bits
    // opb: multiplicand (shifts left) / divisor magnitude
    logic [XLEN-1:0] acc;
    logic [XLEN-1:0] opa;
    logic [XLEN-1:0] opb;
    logic [XLEN-1:0] result_q;

    logic is_mul_q;
    logic is_rem_q;
    logic word_q;
    logic neg_q;
    logic neg_r;

    logic            op_valid;
    logic            op_signed;
    logic            op_div;
    logic            op_rem;
    logic [XLEN-1:0] a_ext;
    logic [XLEN-1:0] b_ext;
    logic [XLEN-1:0] min_val;
    logic            sign_a;
    logic            sign_b;
    logic [XLEN-1:0] mag_a;
    logic [XLEN-1:0] mag_b;
    logic            div_by_zero;
    logic            overflow;
    logic            take_fast;
    logic [XLEN-1:0] fast_result;

    // Operand preparation for a request being accepted this cycle. W forms
    // narrow to 32 bits first; only DIV/REM treat the operands as signed, and
    // the divider itself always works on magnitudes. Divide-by-zero, MIN/-1
    // and reserved opcodes have fixed answers and skip the iteration entirely.
    always_comb begin
        op_valid  = (bus.op_i <= OP_REMU);
        op_signed = (bus.op_i == OP_DIV) || (bus.op_i == OP_REM);
        op_div    = op_valid && (bus.op_i != OP_MUL);
        op_rem    = (bus.op_i == OP_REM) || (bus.op_i == OP_REMU);

        if (bus.word_i) begin
            a_ext   = op_signed ? sext32(bus.a_i[31:0]) : {{(XLEN-32){1'b0}}, bus.a_i[31:0]};
            b_ext   = op_signed ? sext32(bus.b_i[31:0]) : {{(XLEN-32){1'b0}}, bus.b_i[31:0]};
            min_val = sext32(32'h8000_0000);
        end else begin
            a_ext   = bus.a_i;
            b_ext   = bus.b_i;
            min_val = {1'b1, {(XLEN-1){1'b0}}};
        end

        sign_a = op_signed && a_ext[XLEN-1];
        sign_b = op_signed && b_ext[XLEN-1];
        mag_a  = sign_a ? -a_ext : a_ext;
        mag_b  = sign_b ? -b_ext : b_ext;

        div_by_zero = (b_ext == '0);
        overflow    = op_signed && (a_ext == min_val) && (b_ext == '1);
        take_fast   = !op_valid || (op_div && (div_by_zero || overflow));

        fast_result = '0;
        if (op_div && div_by_zero) begin
            if (op_rem) begin
                fast_result = bus.word_i ? sext32(bus.a_i[31:0]) : bus.a_i;
            end else begin
                fast_result = '1;
            end
        end else if (op_div && overflow) begin
            fast_result = op_rem ? '0 : a_ext;
        end
    end

    logic [XLEN:0]   div_shift;
    logic [XLEN:0]   div_diff;
    logic [XLEN-1:0] q_fixed;
    logic [XLEN-1:0] r_fixed;
    logic [XLEN-1:0] raw_result;
    logic [XLEN-1:0] final_result;

    // One restoring-division step plus the sign/width fix-up applied in the
    // cycle after the last iteration. A set top bit in div_diff means the
    // trial subtraction went negative and the partial remainder is kept.
    always_comb begin
        div_shift = {acc, opa[XLEN-1]};
        div_diff  = div_shift - {1'b0, opb};
        q_fixed   = neg_q ? -opa : opa;
        r_fixed   = neg_r ? -acc : acc;

        if (is_mul_q) begin
            raw_result = acc;
        end else if (is_rem_q) begin
            raw_result = r_fixed;
        end else begin
            raw_result = q_fixed;
        end

        final_result = word_q ? sext32(raw_result[31:0]) : raw_result;
    end

    assign iter_limit = word_q ? CNT_W'(32) : CNT_W'(XLEN);

    // Control and datapath registers. Flush beats everything except reset and
    // leaves the last result visible. IDLE and DONE both accept a new request
    // so that consecutive operations run without a gap cycle. In W divides the
    // dividend is parked in the upper half so the same MSB-first shift serves
    // both widths with only 32 iterations.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= S_IDLE;
            count    <= '0;
            acc      <= '0;
            opa      <= '0;
            opb      <= '0;
            result_q <= '0;
            is_mul_q <= 1'b0;
            is_rem_q <= 1'b0;
            word_q   <= 1'b0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
        end else if (bus.flush_i) begin
            state <= S_IDLE;
            count <= '0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (bus.valid_i) begin
                        is_mul_q <= (bus.op_i == OP_MUL);
                        is_rem_q <= op_rem;
                        word_q   <= bus.word_i;
                        neg_q    <= sign_a ^ sign_b;
                        neg_r    <= sign_a;
                        count    <= '0;
                        acc      <= '0;
                        if (bus.op_i == OP_MUL) begin
                            opa <= b_ext;
                            opb <= a_ext;
                        end else begin
                            opa <= bus.word_i ? (mag_a << (XLEN-32)) : mag_a;
                            opb <= mag_b;
                        end
                        if (take_fast) begin
                            result_q <= fast_result;
                            state    <= S_DONE;
                        end else begin
                            state <= S_CALC;
                        end
                    end else begin
                        state <= S_IDLE;
                    end
                end
                S_CALC: begin
                    if (count == iter_limit) begin
                        result_q <= final_result;
                        state    <= S_DONE;
                    end else begin
                        count <= count + CNT_W'(1);
                        if (is_mul_q) begin
                            acc <= acc + (opa[0] ? opb : '0);
                            opa <= opa >> 1;
                            opb <= opb << 1;
                        end else if (!div_diff[XLEN]) begin
                            acc <= div_diff[XLEN-1:0];
                            opa <= {opa[XLEN-2:0], 1'b1};
                        end else begin
                            acc <= div_shift[XLEN-1:0];
                            opa <= {opa[XLEN-2:0], 1'b0};
                        end
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.busy_o   = (state == S_CALC);
    assign bus.done_o   = (state == S_DONE);
    assign bus.result_o = result_q;

    // Execute must never present a new request while an operation iterates.
    assert property (@(posedge clk) disable iff (reset)
        !((state == S_CALC) && bus.valid_i && !bus.flush_i));

endmodule

// File: tb/tb_muldiv_unit.sv
// ---------------------------------------------------------------------------
// tb_muldiv_unit
// Self-checking bench for muldiv_unit. Expected results come from a
// behavioural model built on the simulator's own arithmetic operators, with
// the special cases (divide by zero, MIN/-1, reserved ops, W sign extension)
// written out directly. Latency is counted as rising edges after the edge
// that accepts the request: 0 for the fast path, N+1 for an iterated op.
// ---------------------------------------------------------------------------
module tb_muldiv_unit;

    localparam int XLEN = 64;

    localparam logic [2:0] OP_MUL  = 3'd0;
    localparam logic [2:0] OP_DIV  = 3'd1;
    localparam logic [2:0] OP_DIVU = 3'd2;
    localparam logic [2:0] OP_REM  = 3'd3;
    localparam logic [2:0] OP_REMU = 3'd4;

    localparam logic [63:0] MIN64 = 64'h8000_0000_0000_0000;

    logic clk = 1'b0;
    logic reset;

    int n_checks = 0;
    int n_fails  = 0;

    typedef struct packed {
        logic [2:0]  op;
        logic        word;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] exp;
        logic [7:0]  lat;
    } vec_t;

    always #5 clk = ~clk;

    muldiv_if #(.XLEN(XLEN)) bus ();

    muldiv_unit #(.XLEN(XLEN), .CNT_W(7)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Reference result from plain operators; special cases handled first so
    // no undefined division is ever evaluated.
    function automatic logic [63:0] ref_result(input logic [2:0] op, input logic word,
                                               input logic [63:0] a, input logic [63:0] b);
        logic signed [63:0] sa, sb;
        logic signed [31:0] sa32, sb32;
        logic [31:0]        r32;
        sa   = a;
        sb   = b;
        sa32 = a[31:0];
        sb32 = b[31:0];
        if (!word) begin
            case (op)
                OP_MUL:  return a * b;
                OP_DIV:  if (b == 0) return '1;
                         else if (a == MIN64 && b == '1) return MIN64;
                         else return sa / sb;
                OP_DIVU: return (b == 0) ? '1 : a / b;
                OP_REM:  if (b == 0) return a;
                         else if (a == MIN64 && b == '1) return 0;
                         else return sa % sb;
                OP_REMU: return (b == 0) ? a : a % b;
                default: return 0;
            endcase
        end
        case (op)
            OP_MUL:  r32 = a[31:0] * b[31:0];
            OP_DIV:  if (b[31:0] == 0) r32 = '1;
                     else if (a[31:0] == 32'h8000_0000 && b[31:0] == '1) r32 = 32'h8000_0000;
                     else r32 = sa32 / sb32;
            OP_DIVU: r32 = (b[31:0] == 0) ? '1 : a[31:0] / b[31:0];
            OP_REM:  if (b[31:0] == 0) r32 = a[31:0];
                     else if (a[31:0] == 32'h8000_0000 && b[31:0] == '1) r32 = 0;
                     else r32 = sa32 % sb32;
            OP_REMU: r32 = (b[31:0] == 0) ? a[31:0] : a[31:0] % b[31:0];
            default: return 0;
        endcase
        return {{32{r32[31]}}, r32};
    endfunction

    // Expected edges from accept to done_o.
    function automatic int ref_latency(input logic [2:0] op, input logic word,
                                       input logic [63:0] a, input logic [63:0] b);
        logic signed_op;
        signed_op = (op == OP_DIV) || (op == OP_REM);
        if (op > OP_REMU) return 0;
        if (op == OP_MUL) return word ? 33 : 65;
        if (word) begin
            if (b[31:0] == 0) return 0;
            if (signed_op && a[31:0] == 32'h8000_0000 && b[31:0] == '1) return 0;
            return 33;
        end
        if (b == 0) return 0;
        if (signed_op && a == MIN64 && b == '1) return 0;
        return 65;
    endfunction

    function automatic logic [63:0] pick_operand();
        case ($urandom_range(0, 6))
            0: return 64'(signed'(32'($urandom_range(0, 40)) - 32'sd20));
            1: return 0;
            2: return '1;
            3: return MIN64;
            4: return {32'($urandom), 32'h8000_0000};
            5: return {32'($urandom), 32'($urandom_range(0, 1000))};
            default: return {32'($urandom), 32'($urandom)};
        endcase
    endfunction

    // Present one request for a single accepting edge, leaving time at #1
    // after that edge.
    task automatic start_op(input logic [2:0] op, input logic word,
                            input logic [63:0] a, input logic [63:0] b);
        bus.op_i    = op;
        bus.word_i  = word;
        bus.a_i     = a;
        bus.b_i     = b;
        bus.valid_i = 1'b1;
        @(posedge clk);
        #1;
        bus.valid_i = 1'b0;
    endtask

    // Count edges until done_o is seen; -1 if it never arrives.
    task automatic wait_done(output int edges);
        edges = 0;
        while (bus.done_o !== 1'b1 && edges <= 200) begin
            @(posedge clk);
            #1;
            edges++;
        end
        if (bus.done_o !== 1'b1) edges = -1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        bus.valid_i = 1'b0;
        bus.flush_i = 1'b0;
        bus.op_i    = '0;
        bus.word_i  = 1'b0;
        bus.a_i     = '0;
        bus.b_i     = '0;
        #2 reset = 1'b1;
        #1;
        n_checks++;
        if (bus.busy_o !== 1'b0) begin n_fails++; $display("[TB] FAIL reset_busy: got %b expected 0", bus.busy_o); end
        n_checks++;
        if (bus.done_o !== 1'b0) begin n_fails++; $display("[TB] FAIL reset_done: got %b expected 0", bus.done_o); end
        n_checks++;
        if (bus.result_o !== 64'd0) begin n_fails++; $display("[TB] FAIL reset_result: got %h expected 0", bus.result_o); end
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk);
        #1;
        n_checks++;
        if (bus.busy_o !== 1'b0 || bus.done_o !== 1'b0) begin
            n_fails++;
            $display("[TB] FAIL post_reset_idle: got busy=%b done=%b expected 0/0", bus.busy_o, bus.done_o);
        end
    endtask

    task automatic test_directed();
        vec_t vecs [18];
        int   edges;
        vecs = '{
            '{OP_MUL,  1'b0, 64'd3, 64'hFFFF_FFFF_FFFF_FFFB, 64'hFFFF_FFFF_FFFF_FFF1, 8'd65},
            '{OP_DIV,  1'b1, 64'h0000_0001_8000_0000, 64'd2, 64'hFFFF_FFFF_C000_0000, 8'd33},
            '{OP_REMU, 1'b0, 64'd17, 64'd5, 64'd2, 8'd65},
            '{OP_DIV,  1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 8'd65},
            '{OP_REM,  1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 8'd65},
            '{OP_REM,  1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 64'd1, 8'd65},
            '{OP_DIVU, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'h7FFF_FFFF_FFFF_FFFF, 8'd65},
            '{OP_DIV,  1'b0, 64'd9, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 8'd0},
            '{OP_REM,  1'b0, 64'd9, 64'd0, 64'd9, 8'd0},
            '{OP_DIV,  1'b0, MIN64, 64'hFFFF_FFFF_FFFF_FFFF, MIN64, 8'd0},
            '{OP_REM,  1'b0, MIN64, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 8'd0},
            '{OP_DIV,  1'b1, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 64'hFFFF_FFFF_8000_0000, 8'd0},
            '{OP_REM,  1'b1, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 64'd0, 8'd0},
            '{OP_DIVU, 1'b1, 64'd5, 64'h0000_0001_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 8'd0},
            '{OP_REMU, 1'b1, 64'h0000_0001_8000_0005, 64'h0000_0001_0000_0000, 64'hFFFF_FFFF_8000_0005, 8'd0},
            '{3'd5,    1'b0, 64'd1, 64'd1, 64'd0, 8'd0},
            '{OP_MUL,  1'b1, 64'hDEAD_0000_0000_FFFF, 64'h1234_0000_0001_0001, 64'hFFFF_FFFF_FFFF_FFFF, 8'd33},
            '{OP_DIVU, 1'b1, 64'h0000_0000_FFFF_FFFF, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 8'd33}
        };
        foreach (vecs[i]) begin
            start_op(vecs[i].op, vecs[i].word, vecs[i].a, vecs[i].b);
            wait_done(edges);
            n_checks++;
            if (edges != int'(vecs[i].lat)) begin
                n_fails++;
                $display("[TB] FAIL dir%0d_latency: got %0d expected %0d", i, edges, vecs[i].lat);
            end
            n_checks++;
            if (bus.result_o !== vecs[i].exp) begin
                n_fails++;
                $display("[TB] FAIL dir%0d_result: got %h expected %h", i, bus.result_o, vecs[i].exp);
            end
            @(posedge clk);
            #1;
            n_checks++;
            if (bus.done_o !== 1'b0 || bus.result_o !== vecs[i].exp) begin
                n_fails++;
                $display("[TB] FAIL dir%0d_pulse_hold: got done=%b result=%h expected done=0 result=%h",
                         i, bus.done_o, bus.result_o, vecs[i].exp);
            end
        end
    endtask

    task automatic test_random();
        logic [2:0]  op;
        logic        word;
        logic [63:0] a, b, exp;
        int          lat, edges;
        for (int i = 0; i < 40; i++) begin
            op   = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
            word = 1'($urandom_range(0, 1));
            a    = pick_operand();
            b    = pick_operand();
            exp  = ref_result(op, word, a, b);
            lat  = ref_latency(op, word, a, b);
            start_op(op, word, a, b);
            wait_done(edges);
            n_checks++;
            if (edges != lat) begin
                n_fails++;
                $display("[TB] FAIL rnd%0d_latency op=%0d w=%b: got %0d expected %0d", i, op, word, edges, lat);
            end
            n_checks++;
            if (bus.result_o !== exp) begin
                n_fails++;
                $display("[TB] FAIL rnd%0d_result op=%0d w=%b a=%h b=%h: got %h expected %h",
                         i, op, word, a, b, bus.result_o, exp);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_flush();
        int edges;
        bit seen_done;
        start_op(OP_REMU, 1'b0, 64'd17, 64'd5);
        wait_done(edges);
        @(posedge clk);
        #1;
        start_op(OP_DIVU, 1'b0, 64'd1000, 64'd3);
        repeat (9) begin
            @(posedge clk);
            #1;
        end
        n_checks++;
        if (bus.busy_o !== 1'b1) begin n_fails++; $display("[TB] FAIL flush_prebusy: got %b expected 1", bus.busy_o); end
        // Flush with a simultaneous request: the request must be dropped.
        bus.flush_i = 1'b1;
        bus.valid_i = 1'b1;
        bus.op_i    = OP_MUL;
        bus.word_i  = 1'b0;
        bus.a_i     = 64'd5;
        bus.b_i     = 64'd5;
        @(posedge clk);
        #1;
        bus.flush_i = 1'b0;
        bus.valid_i = 1'b0;
        n_checks++;
        if (bus.busy_o !== 1'b0 || bus.done_o !== 1'b0 || bus.result_o !== 64'd2) begin
            n_fails++;
            $display("[TB] FAIL flush_abort: got busy=%b done=%b result=%h expected 0/0/2",
                     bus.busy_o, bus.done_o, bus.result_o);
        end
        seen_done = 1'b0;
        repeat (70) begin
            @(posedge clk);
            #1;
            if (bus.done_o === 1'b1 || bus.busy_o === 1'b1) seen_done = 1'b1;
        end
        n_checks++;
        if (seen_done || bus.result_o !== 64'd2) begin
            n_fails++;
            $display("[TB] FAIL flush_quiet: got activity=%b result=%h expected 0 and 2", seen_done, bus.result_o);
        end
        start_op(OP_DIVU, 1'b0, 64'd1000, 64'd3);
        wait_done(edges);
        n_checks++;
        if (edges != 65 || bus.result_o !== 64'd333) begin
            n_fails++;
            $display("[TB] FAIL flush_recover: got edges=%0d result=%h expected 65 and 14d", edges, bus.result_o);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_back_to_back();
        int          edges;
        logic [63:0] a2, b2, exp1, exp2;
        exp1 = ref_result(OP_DIV, 1'b0, 64'hFFFF_FFFF_FFFF_FF9C, 64'd7);
        a2   = {32'($urandom), 32'($urandom)};
        b2   = {32'($urandom), 32'($urandom)};
        exp2 = ref_result(OP_MUL, 1'b1, a2, b2);
        start_op(OP_DIV, 1'b0, 64'hFFFF_FFFF_FFFF_FF9C, 64'd7);
        wait_done(edges);
        n_checks++;
        if (edges != 65 || bus.result_o !== exp1) begin
            n_fails++;
            $display("[TB] FAIL b2b_first: got edges=%0d result=%h expected 65 and %h", edges, bus.result_o, exp1);
        end
        start_op(OP_MUL, 1'b1, a2, b2);
        n_checks++;
        if (bus.busy_o !== 1'b1 || bus.done_o !== 1'b0) begin
            n_fails++;
            $display("[TB] FAIL b2b_nogap: got busy=%b done=%b expected 1/0", bus.busy_o, bus.done_o);
        end
        wait_done(edges);
        n_checks++;
        if (edges != 33 || bus.result_o !== exp2) begin
            n_fails++;
            $display("[TB] FAIL b2b_second: got edges=%0d result=%h expected 33 and %h", edges, bus.result_o, exp2);
        end
        // Fast-path request presented during DONE completes on the very next edge.
        start_op(OP_DIVU, 1'b0, 64'd42, 64'd0);
        n_checks++;
        if (bus.done_o !== 1'b1 || bus.result_o !== 64'hFFFF_FFFF_FFFF_FFFF) begin
            n_fails++;
            $display("[TB] FAIL b2b_fast: got done=%b result=%h expected 1 and all ones", bus.done_o, bus.result_o);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid_op();
        int edges;
        bit seen;
        start_op(OP_MUL, 1'b0, 64'h0123_4567_89AB_CDEF, 64'h0FED_CBA9_8765_4321);
        repeat (20) begin
            @(posedge clk);
            #1;
        end
        n_checks++;
        if (bus.busy_o !== 1'b1) begin n_fails++; $display("[TB] FAIL rstmid_prebusy: got %b expected 1", bus.busy_o); end
        #2 reset = 1'b1;
        #1;
        n_checks++;
        if (bus.busy_o !== 1'b0 || bus.done_o !== 1'b0 || bus.result_o !== 64'd0) begin
            n_fails++;
            $display("[TB] FAIL rstmid_async: got busy=%b done=%b result=%h expected 0/0/0",
                     bus.busy_o, bus.done_o, bus.result_o);
        end
        @(posedge clk);
        #1 reset = 1'b0;
        seen = 1'b0;
        repeat (70) begin
            @(posedge clk);
            #1;
            if (bus.done_o === 1'b1 || bus.busy_o === 1'b1) seen = 1'b1;
        end
        n_checks++;
        if (seen) begin n_fails++; $display("[TB] FAIL rstmid_nodone: got activity=1 expected 0"); end
        start_op(OP_REM, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2);
        wait_done(edges);
        n_checks++;
        if (edges != 65 || bus.result_o !== 64'hFFFF_FFFF_FFFF_FFFF) begin
            n_fails++;
            $display("[TB] FAIL rstmid_recover: got edges=%0d result=%h expected 65 and all ones", edges, bus.result_o);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_flush();
        test_back_to_back();
        test_reset_mid_op();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
